// File: rtl/spike_image_sequencer.sv
// Batch sequencer for the LFSR spike encoder: loads each image's pixels into the encoder,
// runs a presentation window and a rest window, then clears the encoder for the next image.
module spike_image_sequencer #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned PIX_W      = 32,
  parameter int unsigned PIX_AW     = 10,
  parameter int unsigned IMG_AW     = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [IMG_AW-1:0] cfg_num_img,
  input  logic [CNT_W-1:0]  cfg_present,
  input  logic [CNT_W-1:0]  cfg_rest,
  output logic              mem_rd_en,
  output logic [IMG_AW-1:0] mem_img,
  output logic [PIX_AW-1:0] mem_pix,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              pix_wr_en,
  output logic [PIX_AW-1:0] pix_wr_idx,
  output logic [PIX_W-1:0]  pix_wr_data,
  output logic              enc_enable,
  output logic              enc_clear,
  output logic              img_done,
  output logic [IMG_AW-1:0] img_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StLoad, StPresent, StRest} state_e;

  localparam logic [PIX_AW-1:0] LastPix = PIX_AW'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);

  state_e              state_q, state_d;
  logic [IMG_AW-1:0]   img_q, img_d;
  logic [PIX_AW-1:0]   pix_q, pix_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IMG_AW-1:0]   num_q, num_d;
  logic [CNT_W-1:0]    pres_q, pres_d;
  logic [CNT_W-1:0]    rest_q, rest_d;
  logic                rd_en_q, rd_en_d;
  logic [IMG_AW-1:0]   mem_img_q, mem_img_d;
  logic [PIX_AW-1:0]   mem_pix_q, mem_pix_d;
  logic                wr_en_q, wr_en_d;
  logic [PIX_AW-1:0]   wr_idx_q, wr_idx_d;
  logic                win_q, win_d;
  logic                clear_q, clear_d;
  logic                img_done_q, img_done_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    img_d      = img_q;
    pix_d      = pix_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    pres_d     = pres_q;
    rest_d     = rest_q;
    rd_en_d    = 1'b0;
    mem_img_d  = '0;
    mem_pix_d  = '0;
    wr_en_d    = 1'b0;
    wr_idx_d   = '0;
    win_d      = 1'b0;
    clear_d    = 1'b0;
    img_done_d = 1'b0;
    done_d     = 1'b0;

    if (abort) begin
      state_d = StIdle;
      img_d   = '0;
      pix_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            num_d  = cfg_num_img;
            pres_d = (cfg_present == '0) ? CntOne : cfg_present;
            rest_d = (cfg_rest == '0) ? CntOne : cfg_rest;
            if (cfg_num_img == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StLoad;
              img_d   = '0;
              pix_d   = '0;
              rd_en_d = 1'b1;
            end
          end
        end
        StLoad: begin
          // Write lags the read by one cycle so it lines up with the memory's read latency.
          wr_en_d  = rd_en_q;
          wr_idx_d = rd_en_q ? pix_q : '0;
          if (rd_en_q) begin
            if (pix_q != LastPix) begin
              pix_d     = pix_q + PIX_AW'(1);
              rd_en_d   = 1'b1;
              mem_pix_d = pix_q + PIX_AW'(1);
              mem_img_d = img_q;
            end
          end else begin
            state_d = StPresent;
            cnt_d   = '0;
            win_d   = 1'b1;
          end
        end
        StPresent: begin
          win_d = 1'b1;
          // Only unpaused cycles count, so pause stretches the window instead of shortening it.
          if (!pause) begin
            if (cnt_q == pres_q - CntOne) begin
              state_d    = StRest;
              win_d      = 1'b0;
              cnt_d      = '0;
              img_done_d = 1'b1;
              clear_d    = (rest_q == CntOne);
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end
        StRest: begin
          if (cnt_q == rest_q - CntOne) begin
            if (img_q == num_q - IMG_AW'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d   = StLoad;
              img_d     = img_q + IMG_AW'(1);
              pix_d     = '0;
              rd_en_d   = 1'b1;
              mem_img_d = img_q + IMG_AW'(1);
            end
          end else begin
            cnt_d   = cnt_q + CntOne;
            clear_d = (cnt_q + CntOne == rest_q - CntOne);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      img_q      <= '0;
      pix_q      <= '0;
      cnt_q      <= '0;
      num_q      <= '0;
      pres_q     <= '0;
      rest_q     <= '0;
      rd_en_q    <= 1'b0;
      mem_img_q  <= '0;
      mem_pix_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      win_q      <= 1'b0;
      clear_q    <= 1'b0;
      img_done_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_q      <= img_d;
      pix_q      <= pix_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      pres_q     <= pres_d;
      rest_q     <= rest_d;
      rd_en_q    <= rd_en_d;
      mem_img_q  <= mem_img_d;
      mem_pix_q  <= mem_pix_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      win_q      <= win_d;
      clear_q    <= clear_d;
      img_done_q <= img_done_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd_en   = rd_en_q;
  assign mem_img     = mem_img_q;
  assign mem_pix     = mem_pix_q;
  assign pix_wr_en   = wr_en_q;
  assign pix_wr_idx  = wr_idx_q;
  // Read data arrives in the write cycle itself, so it passes straight through.
  assign pix_wr_data = wr_en_q ? mem_rd_data : '0;
  assign enc_enable  = win_q & ~pause;
  assign enc_clear   = clear_q;
  assign img_done    = img_done_q;
  assign img_idx     = img_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;

endmodule

// File: tb/tb_spike_image_sequencer.sv
// Bench for spike_image_sequencer: per-cycle output trace compared against a schedule
// built from the window rules, with a one-cycle-latency pixel memory model.
module tb_spike_image_sequencer;

  localparam int N    = 4;
  localparam int MaxC = 2048;

  logic        clk = 1'b0;
  logic        reset, start, abort, pause;
  logic [7:0]  cfg_num_img;
  logic [15:0] cfg_present, cfg_rest;
  logic        mem_rd_en;
  logic [7:0]  mem_img;
  logic [9:0]  mem_pix;
  logic [31:0] mem_rd_data;
  logic        pix_wr_en;
  logic [9:0]  pix_wr_idx;
  logic [31:0] pix_wr_data;
  logic        enc_enable, enc_clear, img_done, busy, done;
  logic [7:0]  img_idx;

  spike_image_sequencer #(
    .NUM_PIXELS(N), .PIX_W(32), .PIX_AW(10), .IMG_AW(8), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .cfg_num_img(cfg_num_img), .cfg_present(cfg_present), .cfg_rest(cfg_rest),
    .mem_rd_en(mem_rd_en), .mem_img(mem_img), .mem_pix(mem_pix), .mem_rd_data(mem_rd_data),
    .pix_wr_en(pix_wr_en), .pix_wr_idx(pix_wr_idx), .pix_wr_data(pix_wr_data),
    .enc_enable(enc_enable), .enc_clear(enc_clear), .img_done(img_done),
    .img_idx(img_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Pixel memory: data valid exactly one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 32'hA0 + 32'(mem_pix) + (32'(mem_img) << 8);
    else           mem_rd_data <= 32'hDEAD_BEEF;
  end

  int checks = 0;
  int failures = 0;

  logic       pz[MaxC];
  logic       e_rd[MaxC], e_wr[MaxC], e_en[MaxC], e_cl[MaxC], e_id[MaxC], e_bz[MaxC], e_dn[MaxC];
  logic [7:0] e_mi[MaxC], e_ix[MaxC];
  logic [9:0] e_mp[MaxC], e_wi[MaxC];
  logic [31:0] e_wd[MaxC];
  int last;

  function automatic logic [74:0] pk(logic rd, logic [7:0] mi, logic [9:0] mp, logic wr,
                                     logic [9:0] wi, logic [31:0] wd, logic en, logic cl,
                                     logic id, logic [7:0] ix, logic bz, logic dn);
    return {rd, mi, mp, wr, wi, wd, en, cl, id, (bz ? ix : 8'd0), bz, dn};
  endfunction

  // Expected schedule from the rules: N reads, one drain, P unpaused enable cycles, R rest.
  task automatic build(input int num, input int pres, input int rest, input int ab);
    int p_len, r_len, t, cnt;
    p_len = (pres == 0) ? 1 : pres;
    r_len = (rest == 0) ? 1 : rest;
    for (int c = 0; c < MaxC; c++) begin
      e_rd[c] = 0; e_wr[c] = 0; e_en[c] = 0; e_cl[c] = 0; e_id[c] = 0; e_bz[c] = 0;
      e_dn[c] = 0; e_mi[c] = 0; e_ix[c] = 0; e_mp[c] = 0; e_wi[c] = 0; e_wd[c] = 0;
    end
    if (num == 0) begin
      e_dn[1] = 1;
      last = 1;
    end else begin
      t = 1;
      for (int k = 0; k < num; k++) begin
        for (int p = 0; p < N; p++) begin
          e_rd[t+p] = 1; e_mp[t+p] = 10'(p); e_mi[t+p] = 8'(k);
          e_wr[t+p+1] = 1; e_wi[t+p+1] = 10'(p);
          e_wd[t+p+1] = 32'hA0 + 32'(p) + (32'(k) << 8);
        end
        for (int q = 0; q <= N; q++) begin
          e_bz[t+q] = 1; e_ix[t+q] = 8'(k);
        end
        t += N + 1;
        cnt = 0;
        while (cnt < p_len && t < MaxC - 8) begin
          e_bz[t] = 1; e_ix[t] = 8'(k);
          if (!pz[t]) begin
            e_en[t] = 1;
            cnt++;
          end
          t++;
        end
        e_id[t] = 1;
        for (int r = 0; r < r_len; r++) begin
          e_bz[t] = 1; e_ix[t] = 8'(k);
          t++;
        end
        e_cl[t-1] = 1;
      end
      e_dn[t] = 1;
      last = t;
    end
    // Abort takes effect the next cycle: everything quiet from then on.
    if (ab >= 0) begin
      for (int c = ab + 1; c < MaxC; c++) begin
        e_rd[c] = 0; e_wr[c] = 0; e_en[c] = 0; e_cl[c] = 0; e_id[c] = 0; e_bz[c] = 0;
        e_dn[c] = 0; e_mi[c] = 0; e_ix[c] = 0; e_mp[c] = 0; e_wi[c] = 0; e_wd[c] = 0;
      end
    end
  endtask

  task automatic pause_none();
    for (int c = 0; c < MaxC; c++) pz[c] = 0;
  endtask

  task automatic pause_rand();
    for (int c = 0; c < MaxC; c++) pz[c] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run(input string name, input int num, input int pres, input int rest,
                     input int ab, input int xs);
    int len, n_id, n_dn, n_cl, x_id, x_dn, x_cl;
    logic [74:0] obs, exp;
    build(num, pres, rest, ab);
    len = (ab >= 0) ? ab + 3 : last + 3;
    n_id = 0; n_dn = 0; n_cl = 0; x_id = 0; x_dn = 0; x_cl = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == xs);
      if (c == 0) begin
        cfg_num_img = 8'(num); cfg_present = 16'(pres); cfg_rest = 16'(rest);
      end else begin
        cfg_num_img = 8'($urandom); cfg_present = 16'($urandom); cfg_rest = 16'($urandom);
      end
      pause = pz[c];
      abort = (c == ab);
      #1;
      obs = {mem_rd_en, mem_img, mem_pix, pix_wr_en, pix_wr_idx, pix_wr_data, enc_enable,
             enc_clear, img_done, (busy ? img_idx : 8'd0), busy, done};
      exp = pk(e_rd[c], e_mi[c], e_mp[c], e_wr[c], e_wi[c], e_wd[c], e_en[c], e_cl[c],
               e_id[c], e_ix[c], e_bz[c], e_dn[c]);
      checks++;
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s cyc%0d observed=%h expected=%h", name, c, obs, exp);
      end
      n_id += int'(img_done); n_dn += int'(done); n_cl += int'(enc_clear);
      x_id += int'(e_id[c]);  x_dn += int'(e_dn[c]); x_cl += int'(e_cl[c]);
    end
    @(negedge clk);
    start = 0; pause = 0; abort = 0;
    checks++;
    assert ({n_id, n_dn, n_cl} === {x_id, x_dn, x_cl}) else begin
      failures++;
      $error("FAIL %s pulse_counts observed=%0d/%0d/%0d expected=%0d/%0d/%0d",
             name, n_id, n_dn, n_cl, x_id, x_dn, x_cl);
    end
  endtask

  initial begin
    logic [74:0] r_obs;
    int ab;
    reset = 1; start = 0; abort = 0; pause = 0;
    cfg_num_img = 0; cfg_present = 0; cfg_rest = 0;
    repeat (3) @(negedge clk);
    r_obs = {mem_rd_en, mem_img, mem_pix, pix_wr_en, pix_wr_idx, pix_wr_data, enc_enable,
             enc_clear, img_done, img_idx, busy, done};
    checks++;
    assert (r_obs === 75'd0) else begin
      failures++;
      $error("FAIL reset observed=%h expected=0", r_obs);
    end
    reset = 0;
    @(negedge clk);

    pause_none();
    run("basic", 1, 3, 2, -1, -1);
    run("three_img", 3, 2, 3, -1, -1);
    pause_none();
    for (int c = 7; c <= 11; c++) pz[c] = 1;
    run("pause5", 1, 3, 2, -1, -1);
    pause_none();
    run("abort_load", 2, 3, 2, 3, -1);
    run("after_abort", 1, 3, 2, -1, -1);
    run("zero_windows", 2, 0, 0, -1, -1);
    run("zero_images", 0, 5, 5, -1, -1);
    run("start_in_present", 2, 4, 2, -1, N + 2);

    for (int i = 0; i < 8; i++) begin
      pause_rand();
      ab = -1;
      if (i % 3 == 2) ab = int'($urandom_range(1, 12));
      run("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
          int'($urandom_range(0, 4)), ab, int'($urandom_range(N + 2, N + 4)));
    end

    pause_none();
    run("max_images", 255, 1, 1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
